// File: rtl/cond_flag_stage.sv
// Condition-evaluation stage: gates register/memory/PC writes on the ARM
// condition field and owns the architectural NZCV flags register.
module cond_flag_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_y,
  input  logic [3:0]  alu_flags,
  input  logic [3:0]  cond,
  input  logic [1:0]  flag_w,
  input  logic        reg_w,
  input  logic        mem_w,
  input  logic        pc_s,
  input  logic [3:0]  rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_rd,
  output logic        out_reg_w,
  output logic        out_mem_w,
  output logic        out_pc_s,
  output logic        out_cond_ex,
  output logic [3:0]  flags,
  output logic [15:0] squash_cnt
);

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = cf;
      4'b0011: r = !cf;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = cf & !z;
      4'b1001: r = !cf | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic        out_valid_q,   out_valid_d;
  logic [31:0] out_result_q,  out_result_d;
  logic [3:0]  out_rd_q,      out_rd_d;
  logic        out_reg_w_q,   out_reg_w_d;
  logic        out_mem_w_q,   out_mem_w_d;
  logic        out_pc_s_q,    out_pc_s_d;
  logic        out_cond_ex_q, out_cond_ex_d;
  logic [3:0]  flags_q,       flags_d;
  logic [15:0] squash_cnt_q,  squash_cnt_d;

  logic cond_ex;
  logic accept;

  always_comb begin
    // Condition sees only the registered flags; no bypass from alu_flags.
    cond_ex  = cond_eval(cond, flags_q);
    in_ready = !flush & (!out_valid_q | out_ready);
    accept   = in_valid & in_ready;

    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_rd_d      = out_rd_q;
    out_reg_w_d   = out_reg_w_q;
    out_mem_w_d   = out_mem_w_q;
    out_pc_s_d    = out_pc_s_q;
    out_cond_ex_d = out_cond_ex_q;
    flags_d       = flags_q;
    squash_cnt_d  = squash_cnt_q;

    if (flush) begin
      out_valid_d = 1'b0;
      out_reg_w_d = 1'b0;
      out_mem_w_d = 1'b0;
      out_pc_s_d  = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_result_d  = alu_y;
      out_rd_d      = rd;
      out_cond_ex_d = cond_ex;
      out_reg_w_d   = reg_w & cond_ex;
      out_mem_w_d   = mem_w & cond_ex;
      out_pc_s_d    = pc_s & cond_ex;
      if (cond_ex) begin
        if (flag_w[1]) flags_d[3:2] = alu_flags[3:2];
        if (flag_w[0]) flags_d[1:0] = alu_flags[1:0];
      end else begin
        squash_cnt_d = squash_cnt_q + 16'd1;
      end
    end else if (out_valid_q && out_ready) begin
      // Side-effect strobes must read 0 whenever the slot is empty.
      out_valid_d = 1'b0;
      out_reg_w_d = 1'b0;
      out_mem_w_d = 1'b0;
      out_pc_s_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= 32'd0;
      out_rd_q      <= 4'd0;
      out_reg_w_q   <= 1'b0;
      out_mem_w_q   <= 1'b0;
      out_pc_s_q    <= 1'b0;
      out_cond_ex_q <= 1'b0;
      flags_q       <= 4'd0;
      squash_cnt_q  <= 16'd0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_rd_q      <= out_rd_d;
      out_reg_w_q   <= out_reg_w_d;
      out_mem_w_q   <= out_mem_w_d;
      out_pc_s_q    <= out_pc_s_d;
      out_cond_ex_q <= out_cond_ex_d;
      flags_q       <= flags_d;
      squash_cnt_q  <= squash_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_rd      = out_rd_q;
  assign out_reg_w   = out_reg_w_q;
  assign out_mem_w   = out_mem_w_q;
  assign out_pc_s    = out_pc_s_q;
  assign out_cond_ex = out_cond_ex_q;
  assign flags       = flags_q;
  assign squash_cnt  = squash_cnt_q;

endmodule

// File: tb/tb_cond_flag_stage.sv
// Directed bench for cond_flag_stage: hand-computed expectations for
// condition gating, flags update, backpressure, flush, wrap and reset.
module tb_cond_flag_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_y;
  logic [3:0]  alu_flags;
  logic [3:0]  cond;
  logic [1:0]  flag_w;
  logic        reg_w;
  logic        mem_w;
  logic        pc_s;
  logic [3:0]  rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_reg_w;
  logic        out_mem_w;
  logic        out_pc_s;
  logic        out_cond_ex;
  logic [3:0]  flags;
  logic [15:0] squash_cnt;

  int n_cmp;
  int n_bad;
  logic [15:0] sq_exp;

  cond_flag_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_y(alu_y), .alu_flags(alu_flags), .cond(cond), .flag_w(flag_w),
    .reg_w(reg_w), .mem_w(mem_w), .pc_s(pc_s), .rd(rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_reg_w(out_reg_w), .out_mem_w(out_mem_w),
    .out_pc_s(out_pc_s), .out_cond_ex(out_cond_ex), .flags(flags),
    .squash_cnt(squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference condition: base test from cond[3:1], inverted by cond[0].
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic b;
    case (c[3:1])
      3'd0: b = f[2];
      3'd1: b = f[1];
      3'd2: b = f[3];
      3'd3: b = f[0];
      3'd4: b = f[1] && !f[2];
      3'd5: b = (f[3] == f[0]);
      3'd6: b = !f[2] && (f[3] == f[0]);
      default: b = 1'b1;
    endcase
    return c[0] ? !b : b;
  endfunction

  initial begin
    logic [3:0] fv_tab [5];
    int need;
    fv_tab[0] = 4'b0000; fv_tab[1] = 4'b0100; fv_tab[2] = 4'b1000;
    fv_tab[3] = 4'b1001; fv_tab[4] = 4'b0010;
    n_cmp = 0; n_bad = 0; sq_exp = 16'd0;

    rst_n = 1'b0; in_valid = 1'b0; alu_y = 32'd0; alu_flags = 4'd0;
    cond = 4'd0; flag_w = 2'd0; reg_w = 1'b0; mem_w = 1'b0; pc_s = 1'b0;
    rd = 4'd0; flush = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", flags, 4'h0);
    chk("rst_squash", squash_cnt, 0);
    chk("rst_reg_w", out_reg_w, 0);
    #10 rst_n = 1'b1;

    // First instruction: AL, writes all flags to 0100
    in_valid = 1'b1; alu_y = 32'd0; alu_flags = 4'b0100; cond = 4'b1110;
    flag_w = 2'b11; reg_w = 1'b1; rd = 4'd3;
    #1 chk("s1_in_ready", in_ready, 1);
    step();
    chk("s1_out_valid", out_valid, 1);
    chk("s1_out_reg_w", out_reg_w, 1);
    chk("s1_out_rd", out_rd, 3);
    chk("s1_flags", flags, 4'b0100);
    chk("s1_cond_ex", out_cond_ex, 1);

    // EQ with Z=1 passes
    cond = 4'b0000; flag_w = 2'b00; alu_flags = 4'b0000; rd = 4'd5; alu_y = 32'h1234;
    step();
    chk("s2_cond_ex", out_cond_ex, 1);
    chk("s2_reg_w", out_reg_w, 1);
    chk("s2_result", out_result, 32'h1234);
    chk("s2_flags", flags, 4'b0100);

    // NE with Z=1 fails: squashed, flags held despite flag_w=11
    cond = 4'b0001; flag_w = 2'b11; alu_flags = 4'b1011; mem_w = 1'b1; pc_s = 1'b1;
    step();
    sq_exp++;
    chk("s3_cond_ex", out_cond_ex, 0);
    chk("s3_reg_w", out_reg_w, 0);
    chk("s3_mem_w", out_mem_w, 0);
    chk("s3_pc_s", out_pc_s, 0);
    chk("s3_squash", squash_cnt, sq_exp);
    chk("s3_flags", flags, 4'b0100);

    in_valid = 1'b0; mem_w = 1'b0; pc_s = 1'b0;
    step();
    chk("drain_valid", out_valid, 0);
    chk("drain_reg_w", out_reg_w, 0);

    // Backpressure
    in_valid = 1'b1; cond = 4'b1110; reg_w = 1'b1; rd = 4'd7; alu_y = 32'hAAAA; flag_w = 2'b00;
    step();
    chk("bp_load_valid", out_valid, 1);
    out_ready = 1'b0; alu_y = 32'hBBBB; rd = 4'd8; flag_w = 2'b11; alu_flags = 4'b1111;
    #1 chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_result", out_result, 32'hAAAA);
      chk("bp_rd", out_rd, 7);
      chk("bp_flags", flags, 4'b0100);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 chk("bp_rel_in_ready", in_ready, 1);
    step();
    chk("bp_rel_valid", out_valid, 1);
    chk("bp_rel_result", out_result, 32'hBBBB);
    chk("bp_rel_rd", out_rd, 8);
    chk("bp_rel_flags", flags, 4'b1111);

    // Condition sweep
    for (int f = 0; f < 5; f++) begin
      in_valid = 1'b1; cond = 4'b1110; flag_w = 2'b11; alu_flags = fv_tab[f];
      step();
      chk("sw_flags", flags, fv_tab[f]);
      flag_w = 2'b00;
      for (int c = 0; c < 16; c++) begin
        cond = c[3:0];
        step();
        chk("sw_cond_ex", out_cond_ex, ref_cond(c[3:0], fv_tab[f]));
        if (!ref_cond(c[3:0], fv_tab[f])) sq_exp++;
      end
      chk("sw_nv_ref", ref_cond(4'b1111, fv_tab[f]), 0);
      chk("sw_squash", squash_cnt, sq_exp);
    end

    // Flush during stall
    cond = 4'b1110; reg_w = 1'b1; flag_w = 2'b00;
    step();
    chk("fl_valid_pre", out_valid, 1);
    out_ready = 1'b0; flush = 1'b1; flag_w = 2'b11; alu_flags = 4'b1111;
    #1 chk("fl_in_ready", in_ready, 0);
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_reg_w", out_reg_w, 0);
    chk("fl_flags", flags, 4'b0010);
    chk("fl_squash", squash_cnt, sq_exp);
    flush = 1'b0; out_ready = 1'b1;

    // Squash counter wrap
    cond = 4'b1111; flag_w = 2'b11; alu_flags = 4'b1111; in_valid = 1'b1;
    need = 16'hFFFF - sq_exp;
    for (int k = 0; k < need; k++) step();
    chk("wrap_ffff", squash_cnt, 16'hFFFF);
    step();
    chk("wrap_zero", squash_cnt, 16'h0000);
    chk("wrap_flags", flags, 4'b0010);

    // Reset pulse mid-stall, between edges
    cond = 4'b1110; alu_flags = 4'b1010; alu_y = 32'h55; reg_w = 1'b1;
    step();
    chk("rs_flags_pre", flags, 4'b1010);
    out_ready = 1'b0; in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rs_valid", out_valid, 0);
    chk("rs_flags", flags, 4'h0);
    chk("rs_result", out_result, 0);
    chk("rs_reg_w", out_reg_w, 0);
    chk("rs_squash", squash_cnt, 0);
    #1 rst_n = 1'b1;
    #1 chk("rs_in_ready", in_ready, 1);
    step();
    chk("rs_valid_after", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cond_flag_stage.md
COND_FLAG_STAGE -- requirements
Module: cond_flag_stage

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the clock is rising-edge only; the reset is asynchronous, active-low.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream ALU result valid
- in_ready  out  1  stage can accept
- alu_y  in  32  ALU result
- alu_flags  in  4  ALU flags {N,Z,C,V}, bit3=N
- cond  in  4  ARM condition field
- flag_w  in  2  [1]=update N,Z; [0]=update C,V
- reg_w  in  1  register write request
- mem_w  in  1  memory write request
- pc_s  in  1  PC-source request
- rd  in  4  destination register
- flush  in  1  synchronous pipeline flush
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  downstream can accept
- out_result  out  32  registered alu_y
- out_rd  out  4  registered rd
- out_reg_w  out  1  reg_w gated by condition
- out_mem_w  out  1  mem_w gated by condition
- out_pc_s  out  1  pc_s gated by condition
- out_cond_ex  out  1  registered condition result
- flags  out  4  architectural {N,Z,C,V}
- squash_cnt  out  16  count of condition-failed instructions

Function
REQ-003 cond_ex SHALL be evaluated combinationally from cond and the architectural flags register:
- 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
- 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
- 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
- 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0
REQ-004 in_ready SHALL equal !flush & (!out_valid | out_ready).
REQ-005 An accept SHALL occur on a rising edge where in_valid & in_ready.
REQ-006 On accept, the output register SHALL load:
- out_result ← alu_y; out_rd ← rd; out_cond_ex ← cond_ex
- out_reg_w ← reg_w & cond_ex; out_mem_w ← mem_w & cond_ex; out_pc_s ← pc_s & cond_ex
REQ-007 On accept, out_valid SHALL become 1; latency from accept to out_valid is 1 cycle.
REQ-008 On accept with cond_ex=1, flag_w[1] SHALL load N,Z from alu_flags, and flag_w[0] SHALL load C,V from alu_flags.
REQ-009 If cond_ex=0, or on any non-accept cycle, the flags register SHALL hold its value.
REQ-010 A flag update from the instruction accepted at edge k SHALL be visible to cond evaluation of the next instruction accepted at edge k+1 (no bypass of alu_flags into cond evaluation).
REQ-011 When out_valid & out_ready & no accept, out_valid SHALL clear on the edge.
REQ-012 Simultaneous drain and accept SHALL load the new instruction with out_valid remaining 1.
REQ-013 While out_valid & !out_ready, all out_* outputs and the flags register SHALL hold stable.
REQ-014 flush=1 SHALL clear out_valid on the edge, block accept, and leave the flags register and squash_cnt unchanged; flush has priority over out_ready.
REQ-015 squash_cnt SHALL increment by 1 on each accept with cond_ex=0, wrapping FFFF→0000.
REQ-016 All out_* fields SHALL be don't-care when out_valid=0, except that out_reg_w, out_mem_w and out_pc_s SHALL be 0 whenever out_valid=0.

Reset
REQ-017 rst_n=0 SHALL asynchronously set out_valid=0 and flags=0000.
REQ-018 rst_n=0 SHALL asynchronously zero out_result, out_rd, out_reg_w, out_mem_w, out_pc_s, out_cond_ex and squash_cnt.
REQ-019 Reset asserted mid-stall SHALL discard the held instruction; after reset, in_ready=1 while flush=0.

Verification
REQ-020 A bench SHALL cover the following directed scenarios:
- Reset, then accept alu_y=0, alu_flags=0100, cond=1110, flag_w=11, reg_w=1, rd=3 -> next cycle out_valid=1, out_reg_w=1, out_rd=3, flags=0100.
- Back-to-back: first instruction sets flags=0100; second has cond=0000 (EQ), reg_w=1 -> out_cond_ex=1, out_reg_w=1; repeat with cond=0001 -> out_reg_w=0, squash_cnt +1, flags unchanged even with flag_w=11.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no second accept, flags stable; release -> drain and accept on the same edge.
- Condition sweep: for each flags value in {0000, 0100, 1000, 1001, 0010}, all 16 cond codes -> out_cond_ex matches the REQ-003 table; 1111 always 0.
- Flush during stall with out_valid=1 -> next edge out_valid=0, flags unchanged, in_ready=0 during flush.
- squash_cnt at FFFF plus one failed-condition accept -> 0000; rst_n pulse asserted between clock edges -> immediate out_valid=0, flags=0000.
